// File: rtl/pipeline_alu_parity_param_if.sv
// Handshake/data bundle for pipeline_alu_parity_param.
// ALU_FLAGS_EN adds carry_out and zero_flag alongside result.
interface pipeline_alu_parity_param_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       function_code;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             parity_out;
    logic [1:0]       occupancy;
`ifdef ALU_FLAGS_EN
    logic             carry_out;
    logic             zero_flag;

    modport master (
        output in_valid, function_code, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, parity_out, occupancy, carry_out, zero_flag
    );
    modport slave (
        input  in_valid, function_code, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, parity_out, occupancy, carry_out, zero_flag
    );
`else
    modport master (
        output in_valid, function_code, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, parity_out, occupancy
    );
    modport slave (
        input  in_valid, function_code, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, parity_out, occupancy
    );
`endif
endinterface

// File: rtl/pipeline_alu_parity_param.sv
// 3-stage ALU/parity pipeline with valid/ready backpressure and occupancy count.
// Optional macro ALU_FLAGS_EN adds registered carry_out/zero_flag outputs.
module pipeline_alu_parity_param #(
    parameter int WIDTH          = 4,
    parameter bit DROP_ZERO_FUNC = 1'b0
) (
    input  logic                          clock,
    input  logic                          reset,
    pipeline_alu_parity_param_if.slave    bus
);

    logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [2:0]       op1_q, op1_d;
    logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
    logic [WIDTH-1:0] res2_q, res2_d, res3_q, res3_d;
    logic             par3_q, par3_d;

    logic             ready1, ready2, ready3;
    logic             accept, drop_beat;
    logic [2:0]       op_enc;
    logic [WIDTH-1:0] alu_res;

    // Ready ripples back combinationally so a full pipe can still stream.
    assign ready3 = !v3_q || bus.out_ready;
    assign ready2 = !v2_q || ready3;
    assign ready1 = !v1_q || ready2;
    assign accept = bus.in_valid && ready1;
    assign drop_beat = DROP_ZERO_FUNC && (bus.function_code == 8'h00);

    always_comb begin
        op_enc = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (bus.function_code[i]) op_enc = 3'(i);
        end
    end

    always_comb begin
        alu_res = '0;
        case (op1_q)
            3'd0: alu_res = a1_q + b1_q;
            3'd1: alu_res = a1_q - b1_q;
            3'd2: alu_res = a1_q & b1_q;
            3'd3: alu_res = a1_q | b1_q;
            3'd4: alu_res = a1_q ^ b1_q;
            3'd5: alu_res = ~a1_q;
            3'd6: alu_res = {a1_q[WIDTH-2:0], 1'b0};
            3'd7: alu_res = {1'b0, a1_q[WIDTH-1:1]};
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic alu_c;
    logic c2_q, c2_d, c3_q, c3_d, z3_q, z3_d;

    always_comb begin
        alu_c = 1'b0;
        case (op1_q)
            3'd0: alu_c = ((a1_q + b1_q) < a1_q);
            3'd1: alu_c = (a1_q >= b1_q);
            3'd6: alu_c = a1_q[WIDTH-1];
            3'd7: alu_c = a1_q[0];
            default: alu_c = 1'b0;
        endcase
    end

    always_comb begin
        c2_d = c2_q;
        c3_d = c3_q;
        z3_d = z3_q;
        if (ready2 && v1_q) c2_d = alu_c;
        if (ready3 && v2_q) begin
            c3_d = c2_q;
            z3_d = (res2_q == '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c2_q <= 1'b0;
            c3_q <= 1'b0;
            z3_q <= 1'b0;
        end else begin
            c2_q <= c2_d;
            c3_q <= c3_d;
            z3_q <= z3_d;
        end
    end

    assign bus.carry_out = c3_q;
    assign bus.zero_flag = z3_q;
`endif

    // Payload loads only when its stage actually advances; stalled stages hold.
    always_comb begin
        v1_d   = v1_q;
        op1_d  = op1_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        v2_d   = v2_q;
        res2_d = res2_q;
        v3_d   = v3_q;
        res3_d = res3_q;
        par3_d = par3_q;
        if (ready1) begin
            v1_d = accept && !drop_beat;
            if (accept) begin
                op1_d = op_enc;
                a1_d  = bus.operand_a;
                b1_d  = bus.operand_b;
            end
        end
        if (ready2) begin
            v2_d = v1_q;
            if (v1_q) res2_d = alu_res;
        end
        if (ready3) begin
            v3_d = v2_q;
            if (v2_q) begin
                res3_d = res2_q;
                par3_d = ^res2_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            op1_q  <= 3'd0;
            a1_q   <= '0;
            b1_q   <= '0;
            res2_q <= '0;
            res3_q <= '0;
            par3_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            v3_q   <= v3_d;
            op1_q  <= op1_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            res2_q <= res2_d;
            res3_q <= res3_d;
            par3_q <= par3_d;
        end
    end

    assign bus.in_ready   = ready1;
    assign bus.out_valid  = v3_q;
    assign bus.result     = res3_q;
    assign bus.parity_out = par3_q;
    assign bus.occupancy  = {1'b0, v1_q} + {1'b0, v2_q} + {1'b0, v3_q};

endmodule
